// File: rtl/video_cfg_pkg.sv
// Shared definitions for the video mode scheduler: register map, window and
// fetch-lead tables, and the apply-sequence state encoding.
package video_cfg_pkg;

  localparam logic [2:0] AddrVconf  = 3'd0;
  localparam logic [2:0] AddrXoffsL = 3'd1;
  localparam logic [2:0] AddrXoffsH = 3'd2;
  localparam logic [2:0] AddrYoffsL = 3'd3;
  localparam logic [2:0] AddrYoffsH = 3'd4;
  localparam logic [2:0] AddrHsint  = 3'd5;
  localparam logic [2:0] AddrVsintL = 3'd6;
  localparam logic [2:0] AddrVsintH = 3'd7;

  typedef struct packed {
    logic [8:0] hbeg;
    logic [8:0] hend;
    logic [8:0] vbeg;
    logic [8:0] vend;
  } win_t;

  typedef enum logic [2:0] {
    StIdle,
    StPend,
    StCalcH,
    StCalcV,
    StCalcO,
    StCommit
  } state_e;

  function automatic win_t rres_win(input logic [1:0] rres);
    win_t w;
    unique case (rres)
      2'd0:    w = '{hbeg: 9'd140, hend: 9'd396, vbeg: 9'd80, vend: 9'd272};
      2'd1:    w = '{hbeg: 9'd108, hend: 9'd428, vbeg: 9'd76, vend: 9'd276};
      2'd2:    w = '{hbeg: 9'd108, hend: 9'd428, vbeg: 9'd56, vend: 9'd296};
      default: w = '{hbeg: 9'd88,  hend: 9'd448, vbeg: 9'd32, vend: 9'd320};
    endcase
    return w;
  endfunction

  function automatic logic [4:0] mode_go_offs(input logic [1:0] mode);
    logic [4:0] g;
    unique case (mode)
      2'd0:    g = 5'd18;
      2'd1:    g = 5'd8;
      2'd2:    g = 5'd4;
      default: g = 5'd24;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/video_mode_sched_if.sv
// CPU configuration write port of the video mode scheduler.
interface video_mode_sched_if;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_data;

  modport master (output cfg_we, cfg_addr, cfg_data);
  modport slave  (input  cfg_we, cfg_addr, cfg_data);
endinterface

// File: rtl/video_mode_table.sv
// Pure lookup from resolution and mode codes to raster window and fetch lead.
module video_mode_table
  import video_cfg_pkg::*;
(
  input  logic [1:0] rres,
  input  logic [1:0] mode,
  output win_t       win,
  output logic [4:0] go_offs
);

  assign win     = rres_win(rres);
  assign go_offs = mode_go_offs(mode);

endmodule

// File: rtl/video_mode_sched.sv
// Stages CPU configuration writes and applies mode/resolution/X scroll
// atomically at frame start; Y scroll and interrupt position apply at once.
module video_mode_sched
  import video_cfg_pkg::*;
#(
  parameter logic [1:0] RRES_DEF = 2'd0,
  parameter logic [7:0] HINT_DEF = 8'd1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               c3,
  input  logic               frame_start,
  video_mode_sched_if.slave  cfg,
  output logic [8:0]         hpix_beg,
  output logic [8:0]         hpix_end,
  output logic [8:0]         vpix_beg,
  output logic [8:0]         vpix_end,
  output logic [8:0]         hpix_beg_ts,
  output logic [8:0]         hpix_end_ts,
  output logic [8:0]         vpix_beg_ts,
  output logic [8:0]         vpix_end_ts,
  output logic [4:0]         go_offs,
  output logic [1:0]         x_offs,
  output logic [7:0]         cstart,
  output logic [8:0]         rstart,
  output logic [7:0]         hint_beg,
  output logic [8:0]         vint_beg,
  output logic               nogfx,
  output logic               y_offs_wr,
  output logic               busy
);

  state_e     state_q, state_d;
  logic       dirty_q, snap_en, wr_mode, trig;
  logic [1:0] stg_rres_q, stg_rres_d, stg_mode_q, stg_mode_d;
  logic       stg_nogfx_q, stg_nogfx_d;
  logic [8:0] stg_xoffs_q, stg_xoffs_d;
  logic [7:0] stg_yl_q, stg_vl_q;
  logic [1:0] snap_rres_q, snap_mode_q;
  logic       snap_nogfx_q;
  logic [8:0] snap_xoffs_q;
  win_t       calc_win_q, out_win_q, tbl_win;
  logic [4:0] calc_go_q, tbl_go;
  logic [1:0] calc_xo_q;
  logic [7:0] calc_cs_q;

  assign trig    = frame_start && c3;
  assign wr_mode = cfg.cfg_we && (cfg.cfg_addr <= AddrXoffsH);
  assign busy    = (state_q != StIdle);

  // Next staging values, so a write on the trigger cycle lands in the snapshot.
  always_comb begin
    stg_rres_d  = stg_rres_q;
    stg_mode_d  = stg_mode_q;
    stg_nogfx_d = stg_nogfx_q;
    stg_xoffs_d = stg_xoffs_q;
    if (cfg.cfg_we) begin
      case (cfg.cfg_addr)
        AddrVconf: begin
          stg_rres_d  = cfg.cfg_data[7:6];
          stg_nogfx_d = cfg.cfg_data[5];
          stg_mode_d  = cfg.cfg_data[1:0];
        end
        AddrXoffsL: stg_xoffs_d[7:0] = cfg.cfg_data;
        AddrXoffsH: stg_xoffs_d[8]   = cfg.cfg_data[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    snap_en = 1'b0;
    unique case (state_q)
      StIdle:  if (dirty_q) state_d = StPend;
      StPend: begin
        if (trig) begin
          state_d = StCalcH;
          snap_en = 1'b1;
        end
      end
      StCalcH:  state_d = StCalcV;
      StCalcV:  state_d = StCalcO;
      StCalcO:  state_d = StCommit;
      StCommit: state_d = dirty_q ? StPend : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      dirty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dirty_q <= snap_en ? 1'b0 : (wr_mode ? 1'b1 : dirty_q);
    end
  end

  video_mode_table u_table (
    .rres    (snap_rres_q),
    .mode    (snap_mode_q),
    .win     (tbl_win),
    .go_offs (tbl_go)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_rres_q   <= RRES_DEF;
      stg_mode_q   <= 2'd0;
      stg_nogfx_q  <= 1'b0;
      stg_xoffs_q  <= 9'd0;
      stg_yl_q     <= 8'd0;
      stg_vl_q     <= 8'd0;
      snap_rres_q  <= RRES_DEF;
      snap_mode_q  <= 2'd0;
      snap_nogfx_q <= 1'b0;
      snap_xoffs_q <= 9'd0;
      calc_win_q   <= rres_win(RRES_DEF);
      calc_go_q    <= mode_go_offs(2'd0);
      calc_xo_q    <= 2'd0;
      calc_cs_q    <= 8'd0;
      out_win_q    <= rres_win(RRES_DEF);
      go_offs      <= mode_go_offs(2'd0);
      x_offs       <= 2'd0;
      cstart       <= 8'd0;
      nogfx        <= 1'b0;
      rstart       <= 9'd0;
      hint_beg     <= HINT_DEF;
      vint_beg     <= 9'd0;
      y_offs_wr    <= 1'b0;
    end else begin
      stg_rres_q  <= stg_rres_d;
      stg_mode_q  <= stg_mode_d;
      stg_nogfx_q <= stg_nogfx_d;
      stg_xoffs_q <= stg_xoffs_d;
      if (snap_en) begin
        snap_rres_q  <= stg_rres_d;
        snap_mode_q  <= stg_mode_d;
        snap_nogfx_q <= stg_nogfx_d;
        snap_xoffs_q <= stg_xoffs_d;
      end
      if (state_q == StCalcH) begin
        calc_win_q.hbeg <= tbl_win.hbeg;
        calc_win_q.hend <= tbl_win.hend;
      end
      if (state_q == StCalcV) begin
        calc_win_q.vbeg <= tbl_win.vbeg;
        calc_win_q.vend <= tbl_win.vend;
      end
      if (state_q == StCalcO) begin
        calc_go_q <= tbl_go;
        calc_xo_q <= snap_xoffs_q[1:0];
        calc_cs_q <= {1'b0, snap_xoffs_q[8:2]};
      end
      // Every raster-visible field switches on the same edge.
      if (state_q == StCommit) begin
        out_win_q <= calc_win_q;
        go_offs   <= calc_go_q;
        x_offs    <= calc_xo_q;
        cstart    <= calc_cs_q;
        nogfx     <= snap_nogfx_q;
      end
      y_offs_wr <= 1'b0;
      if (cfg.cfg_we) begin
        case (cfg.cfg_addr)
          AddrYoffsL: stg_yl_q <= cfg.cfg_data;
          AddrYoffsH: begin
            rstart    <= {cfg.cfg_data[0], stg_yl_q};
            y_offs_wr <= 1'b1;
          end
          AddrHsint:  hint_beg <= cfg.cfg_data;
          AddrVsintL: stg_vl_q <= cfg.cfg_data;
          AddrVsintH: vint_beg <= {cfg.cfg_data[0], stg_vl_q};
          default: ;
        endcase
      end
    end
  end

  assign hpix_beg    = out_win_q.hbeg;
  assign hpix_end    = out_win_q.hend;
  assign vpix_beg    = out_win_q.vbeg;
  assign vpix_end    = out_win_q.vend;
  assign hpix_beg_ts = out_win_q.hbeg;
  assign hpix_end_ts = out_win_q.hend;
  assign vpix_beg_ts = out_win_q.vbeg;
  assign vpix_end_ts = out_win_q.vend;

endmodule
